shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
Sequential unsigned add-shift multiplier controller. It owns one 64-bit ripple-carry adder and sequences it over WIDTH iterations to form a 2*WIDTH-bit product. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the control and datapath wrapper that lets the shared adder be reused once per cycle instead of building an array multiplier.

Parameters:
WIDTH, 32, operand width; 2*WIDTH must equal 64 (adder width); other values are illegal and are flagged by an elaboration-time check.
EARLY_EXIT, 0, 1 = terminate as soon as the remaining multiplier bits are all zero; 0 = fixed WIDTH-iteration latency.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands (high only in IDLE)
in_a  input  WIDTH  multiplicand (unsigned)
in_b  input  WIDTH  multiplier (unsigned)
out_valid  output  1  product valid (high only in DONE)
out_ready  input  1  consumer accepts product
out_product  output  2*WIDTH  in_a*in_b; holds last value outside DONE
busy  output  1  high in CALC

Behaviour:
- Reset (rst_n=0 at a clk edge) has priority over everything, including mid-CALC and mid-DONE. State becomes IDLE, and acc, mcand, mplier and count are cleared to 0. Outputs after reset: in_ready=1, out_valid=0, busy=0, out_product=0.
- Registers:
  - acc[2W-1:0]: accumulator, driven to out_product.
  - mcand[2W-1:0]: multiplicand, zero-extended.
  - mplier[W-1:0]: multiplier.
  - count: $clog2(WIDTH)+1 bits.
- IDLE: in_ready=1. On an edge with in_valid=1, load mcand={W'0,in_a}, mplier=in_b, acc=0, count=0, and go to CALC. Otherwise hold all registers; acc keeps the previous product.
- CALC: one iteration per edge.
  - If mplier[0]=1, acc <= adder sum of acc and mcand, with Cin=0. Carry-out is ignored; it cannot be set because the product fits in 2W bits.
  - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
  - After the iteration with count==WIDTH-1, go to DONE.
  - If EARLY_EXIT=1 and mplier==0 at the start of the cycle, go to DONE without modifying acc, mcand or count.
- in_valid is ignored in CALC and DONE; operands are not captured, and the producer must hold them.
- DONE: out_valid=1 and out_product=acc, held stable until handshake. On an edge with out_ready=1, go to IDLE. A new operand cannot be accepted in the same edge; the earliest accept is the following edge.
- Latency, counted as edges from the accepting edge to the edge that raises out_valid:
  - EARLY_EXIT=0: exactly WIDTH.
  - EARLY_EXIT=1: b==0 gives 1; otherwise min(WIDTH, msb_index(b)+2).
- Throughput, EARLY_EXIT=0 with out_ready held high: one product per WIDTH+2 cycles.
- The adder is combinational, and there is exactly one instance. The adder inputs are acc and mcand unconditionally; the select happens at the acc register input.
- No X propagation: all state registers have reset values, and there is no latch inference.

Decomposition:
- Shared package shift_add_mult_pkg holds:
  - state enum IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - constant ADDER_W=64;
  - function clog2 for count width.
- One sub-module is natural: the existing 64-bit ripple-carry adder (RCA), instantiated once with Cin tied to 0 and Cout left unconnected.
- FSM, shift registers and counter stay in this module; no further split.

Test Plan:
1. Reset, then a=3, b=5, EARLY_EXIT=0, out_ready=1 → out_valid rises exactly 32 edges after accept; out_product=64'd15; in_ready returns 1 on the next edge.
2. a=32'hFFFFFFFF, b=32'hFFFFFFFF → out_product=64'hFFFFFFFE00000001; no carry-out corruption.
3. EARLY_EXIT=1: b=0 → product 0 after 1 edge; b=5 → 15 after 4 edges; b=32'h80000000, a=2 → 64'h100000000 after 32 edges.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new operands → out_valid and out_product stay stable, in_ready=0, and new operands are not captured; a product is accepted only on the out_ready edge.
5. Drop rst_n for 1 cycle at iteration 12 of CALC → next cycle state IDLE, out_product=0, busy=0, in_ready=1; the next transaction a=7, b=9 yields 63.
6. Random back-to-back: 1000 random a/b pairs with random in_valid/out_ready gaps → each product equals the reference a*b, in order, with no drops or duplicates.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the add-shift multiplier controller: FSM state
// encoding, the width of the shared adder and a width helper for counters.
package shift_add_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the single ripple-carry adder the controller time-shares.
   localparam int ADDER_W = 64;

   // Ceiling log2, usable in constant expressions for counter sizing.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_rca.sv
// Plain ripple-carry adder. The multiplier controller owns one instance and
// reuses it once per iteration.
module shift_add_mult_ctrl_rca
   import shift_add_mult_pkg::*;
#(
   parameter int W = ADDER_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic carry;

   // Walk the carry from bit 0 upward, one full adder per bit.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' so the carry written on
      // one loop pass is visible to the next pass within the same evaluation.
      sum   = '0;
      carry = cin;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned add-shift multiplier. One operand pair is accepted in
// IDLE, the shared adder accumulates one partial product per cycle in CALC,
// and the product is offered in DONE until the consumer takes it.
module shift_add_mult_ctrl
   import shift_add_mult_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = clog2(WIDTH) + 1;

   // The product register and the multiplicand shifter must match the one
   // shared adder exactly; any other operand width is rejected here.
   if (PW != ADDER_W) begin : g_bad_width
      $error("shift_add_mult_ctrl: 2*WIDTH must equal ADDER_W");
   end

   state_t            state;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     mcand;
   logic [WIDTH-1:0]  mplier;
   logic [CW-1:0]     count;

   logic [ADDER_W-1:0] sum;
   logic               unused_cout;

   // The adder always sees acc + mcand; whether the sum is kept is decided at
   // the acc register input. The carry-out cannot be set because the full
   // product fits in PW bits.
   shift_add_mult_ctrl_rca #(
      .W (ADDER_W)
   ) u_rca (
      .a    (acc),
      .b    (mcand),
      .cin  (1'b0),
      .sum  (sum),
      .cout (unused_cout)
   );

   assign out_product = acc;

   // Controller FSM with its datapath registers and registered handshakes.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses non-blocking '<=' so all of them
      // update together from the values present before the edge.
      if (!rst_n) begin
         // NOTE: the datapath registers are reset too, not just the state,
         // so out_product never shows X after reset.
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand    <= PW'(in_a);
                  mplier   <= in_b;
                  acc      <= '0;
                  count    <= '0;
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            CALC: begin
               if (EARLY_EXIT && (mplier == '0)) begin
                  // No set multiplier bits remain, so acc is already final.
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  if (mplier[0]) begin
                     acc <= sum;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + CW'(1);
                  if (count == CW'(WIDTH - 1)) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end

            DONE: begin
               // A new operand is only taken on the edge after this one.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: one instance with fixed latency (index 0)
// and one with early exit (index 1). Expected products go into a scoreboard
// queue when an operand pair is accepted and are popped when a product leaves.
module tb_shift_add_mult_ctrl;

   localparam int W  = 32;
   localparam int TP = W + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid    [2];
   logic        in_ready    [2];
   logic [31:0] in_a        [2];
   logic [31:0] in_b        [2];
   logic        out_valid   [2];
   logic        out_ready   [2];
   logic [63:0] out_product [2];
   logic        busy        [2];

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] sb_q[$];

   shift_add_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid[0]), .in_ready (in_ready[0]),
      .in_a (in_a[0]), .in_b (in_b[0]),
      .out_valid (out_valid[0]), .out_ready (out_ready[0]),
      .out_product (out_product[0]), .busy (busy[0])
   );

   shift_add_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid[1]), .in_ready (in_ready[1]),
      .in_a (in_a[1]), .in_b (in_b[1]),
      .out_valid (out_valid[1]), .out_ready (out_ready[1]),
      .out_product (out_product[1]), .busy (busy[1])
   );

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] wa;
      logic [63:0] wb;
      wa = {32'b0, a};
      wb = {32'b0, b};
      return wa * wb;
   endfunction

   // One transaction with out_ready high: accept, wait for out_valid, take it.
   task automatic do_txn(input int u, input logic [31:0] a, input logic [31:0] b,
                         output bit acc_ok, output int lat, output logic [63:0] prod,
                         output bit rdy_after);
      @(negedge clk);
      acc_ok       = in_ready[u];
      in_a[u]      = a;
      in_b[u]      = b;
      in_valid[u]  = 1'b1;
      out_ready[u] = 1'b1;
      sb_q.push_back(ref_mul(a, b));
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      in_valid[u] = 1'b0;
      while (!out_valid[u] && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      prod = out_product[u];
      @(posedge clk);
      @(negedge clk);
      rdy_after = in_ready[u] && !out_valid[u];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         n_vec++;
         if ({in_ready[u], out_valid[u], busy[u]} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags[%0d]: actual rdy/vld/busy=%b required 100", u,
                     {in_ready[u], out_valid[u], busy[u]});
         end
         n_vec++;
         if (out_product[u] !== 64'd0) begin
            n_err++;
            $display("FAIL reset_product[%0d]: actual %h required 0", u, out_product[u]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bit ok; bit rdy; int lat; logic [63:0] prod; logic [63:0] exp;
      logic [31:0] ta [2] = '{32'd3, 32'hFFFF_FFFF};
      logic [31:0] tb [2] = '{32'd5, 32'hFFFF_FFFF};
      for (int i = 0; i < 2; i++) begin
         do_txn(0, ta[i], tb[i], ok, lat, prod, rdy);
         exp = sb_q.pop_front();
         n_vec++;
         if (!ok) begin n_err++; $display("FAIL basic%0d_accept: in_ready actual 0 required 1", i); end
         n_vec++;
         if (lat != W) begin n_err++; $display("FAIL basic%0d_latency: actual %0d required %0d", i, lat, W); end
         n_vec++;
         if (prod !== exp) begin n_err++; $display("FAIL basic%0d_product: actual %h required %h", i, prod, exp); end
         n_vec++;
         if (!rdy) begin n_err++; $display("FAIL basic%0d_ready_after: in_ready/out_valid not back to idle", i); end
      end
   endtask

   task automatic test_early_exit();
      bit ok; bit rdy; int lat; logic [63:0] prod; logic [63:0] exp;
      logic [31:0] ta [4] = '{32'd123, 32'd3, 32'd2, 32'd7};
      logic [31:0] tb [4] = '{32'd0, 32'd5, 32'h8000_0000, 32'd1};
      int          tl [4] = '{1, 4, 32, 2};
      for (int i = 0; i < 4; i++) begin
         do_txn(1, ta[i], tb[i], ok, lat, prod, rdy);
         exp = sb_q.pop_front();
         n_vec++;
         if (lat != tl[i]) begin n_err++; $display("FAIL early%0d_latency: actual %0d required %0d", i, lat, tl[i]); end
         n_vec++;
         if (prod !== exp) begin n_err++; $display("FAIL early%0d_product: actual %h required %h", i, prod, exp); end
         n_vec++;
         if (!ok || !rdy) begin n_err++; $display("FAIL early%0d_handshake: accept=%b idle_after=%b required 1/1", i, ok, rdy); end
      end
   endtask

   task automatic test_backpressure();
      int wait_c; logic [63:0] exp;
      @(negedge clk);
      in_a[0] = 32'd11; in_b[0] = 32'd13; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
      sb_q.push_back(ref_mul(32'd11, 32'd13));
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      wait_c = 0;
      while (!out_valid[0] && wait_c < 200) begin @(posedge clk); @(negedge clk); wait_c++; end
      exp = sb_q[0];
      for (int k = 0; k < 10; k++) begin
         n_vec++;
         if (!(out_valid[0] === 1'b1 && out_product[0] === exp && in_ready[0] === 1'b0 && busy[0] === 1'b0)) begin
            n_err++;
            $display("FAIL hold%0d: vld=%b rdy=%b busy=%b prod=%h required 1/0/0 prod=%h",
                     k, out_valid[0], in_ready[0], busy[0], out_product[0], exp);
         end
         in_valid[0] = k[0];
         in_a[0] = 32'd99; in_b[0] = 32'd99;
         @(posedge clk);
         @(negedge clk);
      end
      // Release the product while a new pair is already offered.
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_a[0] = 32'd2; in_b[0] = 32'd3;
      exp = sb_q.pop_front();
      n_vec++;
      if (out_product[0] !== exp) begin n_err++; $display("FAIL bp_product: actual %h required %h", out_product[0], exp); end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({in_ready[0], busy[0], out_valid[0]} !== 3'b100) begin
         n_err++;
         $display("FAIL bp_no_same_edge: rdy/busy/vld actual %b required 100", {in_ready[0], busy[0], out_valid[0]});
      end
      sb_q.push_back(ref_mul(32'd2, 32'd3));
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      n_vec++;
      if ({in_ready[0], busy[0]} !== 2'b01) begin
         n_err++;
         $display("FAIL bp_next_accept: rdy/busy actual %b required 01", {in_ready[0], busy[0]});
      end
      wait_c = 0;
      while (!out_valid[0] && wait_c < 200) begin @(posedge clk); @(negedge clk); wait_c++; end
      exp = sb_q.pop_front();
      n_vec++;
      if (out_product[0] !== exp) begin n_err++; $display("FAIL bp_next_product: actual %h required %h", out_product[0], exp); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      bit ok; bit rdy; int lat; logic [63:0] prod; logic [63:0] exp;
      @(negedge clk);
      in_a[0] = 32'd5; in_b[0] = 32'd5; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (busy[0] !== 1'b1) begin n_err++; $display("FAIL mid_busy: actual %b required 1", busy[0]); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_vec++;
      if ({in_ready[0], busy[0], out_valid[0]} !== 3'b100 || out_product[0] !== 64'd0) begin
         n_err++;
         $display("FAIL mid_reset: rdy/busy/vld actual %b prod %h required 100 prod 0",
                  {in_ready[0], busy[0], out_valid[0]}, out_product[0]);
      end
      do_txn(0, 32'd7, 32'd9, ok, lat, prod, rdy);
      exp = sb_q.pop_front();
      n_vec++;
      if (prod !== exp || lat != W) begin
         n_err++;
         $display("FAIL after_reset_txn: actual %h lat %0d required %h lat %0d", prod, lat, exp, W);
      end
   endtask

   task automatic test_back_to_back();
      int cyc; int got; int acc_t[$]; logic [63:0] exp;
      cyc = 0; got = 0;
      @(negedge clk);
      in_a[0] = 32'h1234_5678; in_b[0] = 32'h0BAD_F00D; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      while ((acc_t.size() < 3 || got < 3) && cyc < 300) begin
         if (in_valid[0] && in_ready[0]) begin
            sb_q.push_back(ref_mul(in_a[0], in_b[0]));
            acc_t.push_back(cyc);
         end else if (!in_ready[0]) begin
            in_a[0] = in_a[0] + 32'h1357_9BDF;
            in_b[0] = in_b[0] ^ 32'hA5A5_0F0F;
            if (acc_t.size() == 3) in_valid[0] = 1'b0;
         end
         if (out_valid[0]) begin
            exp = sb_q.pop_front();
            n_vec++;
            if (out_product[0] !== exp) begin n_err++; $display("FAIL b2b_product%0d: actual %h required %h", got, out_product[0], exp); end
            got++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      in_valid[0] = 1'b0;
      n_vec++;
      if (acc_t.size() != 3 || got != 3) begin
         n_err++;
         $display("FAIL b2b_count: accepts %0d products %0d required 3/3", acc_t.size(), got);
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_vec++;
            if (acc_t[i] - acc_t[i-1] != TP) begin
               n_err++;
               $display("FAIL b2b_period%0d: actual %0d required %0d", i, acc_t[i] - acc_t[i-1], TP);
            end
         end
      end
   endtask

   task automatic test_random(input int u, input int n);
      int got; int limit;
      got = 0;
      limit = n * 80;
      fork
         begin
            int  sent = 0;
            int  cyc  = 0;
            bit  acc_pend = 1'b0;
            while (sent < n && cyc < limit) begin
               @(negedge clk);
               cyc++;
               if (acc_pend) begin in_valid[u] = 1'b0; acc_pend = 1'b0; end
               if (!in_valid[u] && $urandom_range(0, 3) != 0) begin
                  in_a[u] = $urandom;
                  in_b[u] = (u == 1) ? ($urandom >> $urandom_range(0, 32)) : $urandom;
                  in_valid[u] = 1'b1;
               end
               if (in_valid[u] && in_ready[u]) begin
                  sb_q.push_back(ref_mul(in_a[u], in_b[u]));
                  sent++;
                  acc_pend = 1'b1;
               end
            end
            @(negedge clk);
            in_valid[u] = 1'b0;
         end
         begin
            int          cyc = 0;
            logic [63:0] exp;
            while (got < n && cyc < limit) begin
               @(negedge clk);
               cyc++;
               out_ready[u] = ($urandom_range(0, 3) != 0);
               if (out_valid[u] && out_ready[u]) begin
                  n_vec++;
                  if (sb_q.size() == 0) begin
                     n_err++;
                     $display("FAIL rand%0d_extra: product %h with nothing outstanding", u, out_product[u]);
                  end else begin
                     exp = sb_q.pop_front();
                     if (out_product[u] !== exp) begin
                        n_err++;
                        $display("FAIL rand%0d_product%0d: actual %h required %h", u, got, out_product[u], exp);
                     end
                  end
                  got++;
               end
            end
         end
      join
      out_ready[u] = 1'b1;
      n_vec++;
      if (got != n || sb_q.size() != 0) begin
         n_err++;
         $display("FAIL rand%0d_count: products %0d outstanding %0d required %0d/0", u, got, sb_q.size(), n);
      end
      sb_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in_valid[u]  = 1'b0;
         in_a[u]      = '0;
         in_b[u]      = '0;
         out_ready[u] = 1'b1;
      end
      test_reset();
      test_basic();
      test_early_exit();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      test_random(0, 600);
      test_random(1, 400);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
